// File: rtl/antitheft_controller.sv
// -----------------------------------------------------------------------------
// antitheft_controller
//
// Vehicle anti-theft sequencer. It arms after a delay once the driver has left,
// counts down an entry delay when a door opens while armed, and gates the
// siren on when that countdown expires. The external countdown timer is loaded
// through start_timer/interval and reports back through the expired pulse.
//
// All outputs are registered. They are computed from the next state and
// captured on the same edge as the state register, so each output lines up
// with the state it describes.
//
// Configuration macro:
//   ANTITHEFT_PASSENGER_DELAY_EN - when defined, a passenger-door trigger loads
//   the passenger delay (interval 10). When undefined, it loads the driver
//   delay (interval 01), and interval never takes the value 10.
// -----------------------------------------------------------------------------
module antitheft_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       reprogram,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic       status,
  output logic       enable_siren,
  output logic       start_timer,
  output logic [1:0] interval
);

  typedef enum logic [2:0] {
    ARMED,
    TRIGGERED,
    ALARM,
    ALARM_HOLD,
    IGN_ON,
    WAIT_OPEN,
    WAIT_CLOSE,
    ARM_DELAY
  } state_t;

  localparam logic [1:0] INT_ARM_DELAY = 2'b00;
  localparam logic [1:0] INT_DRIVER    = 2'b01;
  localparam logic [1:0] INT_PASSENGER = 2'b10;
  localparam logic [1:0] INT_ALARM_ON  = 2'b11;

`ifdef ANTITHEFT_PASSENGER_DELAY_EN
  localparam logic [1:0] INT_PASS_TRIGGER = INT_PASSENGER;
`else
  localparam logic [1:0] INT_PASS_TRIGGER = INT_DRIVER;
`endif

  state_t     state, next_state;
  logic       next_status;
  logic       next_siren;
  logic       next_start;
  logic [1:0] next_interval;

  logic       any_door_open;
  assign any_door_open = door_driver | door_pass;

  // Next-state logic and timer-start requests, with priority reprogram > ignition > events.
  always_comb begin
    // NOTE: every signal gets a default before any branch. An output that is
    // left unassigned on some path makes synthesis infer a latch.
    next_state    = state;
    next_start    = 1'b0;
    next_interval = interval;

    if (reprogram) begin
      next_state    = ARM_DELAY;
      next_start    = 1'b1;
      next_interval = INT_ARM_DELAY;
    end else if (ignition) begin
      next_state = IGN_ON;
    end else begin
      case (state)
        IGN_ON: next_state = WAIT_OPEN;

        WAIT_OPEN: begin
          if (door_driver) next_state = WAIT_CLOSE;
        end

        WAIT_CLOSE: begin
          if (!door_driver) begin
            next_state    = ARM_DELAY;
            next_start    = 1'b1;
            next_interval = INT_ARM_DELAY;
          end
        end

        ARM_DELAY: begin
          // An open door restarts the arm delay, so the timer only runs out
          // once the car has stayed closed for the full delay.
          if (any_door_open) begin
            next_start    = 1'b1;
            next_interval = INT_ARM_DELAY;
          end else if (expired) begin
            next_state = ARMED;
          end
        end

        ARMED: begin
          if (door_driver) begin
            next_state    = TRIGGERED;
            next_start    = 1'b1;
            next_interval = INT_DRIVER;
          end else if (door_pass) begin
            next_state    = TRIGGERED;
            next_start    = 1'b1;
            next_interval = INT_PASS_TRIGGER;
          end
        end

        // Closing the door again does not cancel the entry countdown.
        TRIGGERED: begin
          if (expired) next_state = ALARM;
        end

        ALARM: begin
          if (!any_door_open) begin
            next_state    = ALARM_HOLD;
            next_start    = 1'b1;
            next_interval = INT_ALARM_ON;
          end
        end

        ALARM_HOLD: begin
          if (any_door_open)  next_state = ALARM;
          else if (expired)   next_state = ARMED;
        end

        default: next_state = ARMED;
      endcase
    end
  end

  // Registered-output values derived from the next state.
  always_comb begin
    next_siren  = (next_state == ALARM) || (next_state == ALARM_HOLD);
    next_status = 1'b0;
    case (next_state)
      ARMED: begin
        // The LED blinks only while the block stays armed. On the cycle it
        // enters ARMED the LED starts dark.
        if (state == ARMED) next_status = one_hz_enable ? ~status : status;
        else                next_status = 1'b0;
      end
      TRIGGERED, ALARM, ALARM_HOLD: next_status = 1'b1;
      default:                      next_status = 1'b0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers
    // update together from values sampled before the edge.
    if (reset) begin
      state        <= ARMED;
      status       <= 1'b0;
      enable_siren <= 1'b0;
      start_timer  <= 1'b0;
      interval     <= INT_ARM_DELAY;
    end else begin
      state        <= next_state;
      status       <= next_status;
      enable_siren <= next_siren;
      start_timer  <= next_start;
      interval     <= next_interval;
    end
  end

endmodule

// File: tb/tb_antitheft_controller.sv
// -----------------------------------------------------------------------------
// tb_antitheft_controller
//
// Directed bench for antitheft_controller. Each step drives inputs, advances
// one rising edge, and compares the registered outputs 1 ns after that edge
// against hand-computed values. ANTITHEFT_PASSENGER_DELAY_EN selects the
// expected passenger-trigger interval.
// -----------------------------------------------------------------------------
module tb_antitheft_controller;

  logic       clock;
  logic       reset;
  logic       ignition;
  logic       door_driver;
  logic       door_pass;
  logic       reprogram;
  logic       expired;
  logic       one_hz_enable;
  logic       status;
  logic       enable_siren;
  logic       start_timer;
  logic [1:0] interval;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef ANTITHEFT_PASSENGER_DELAY_EN
  localparam logic [1:0] EXP_PASS_INT = 2'b10;
`else
  localparam logic [1:0] EXP_PASS_INT = 2'b01;
`endif

  antitheft_controller dut (
    .clock        (clock),
    .reset        (reset),
    .ignition     (ignition),
    .door_driver  (door_driver),
    .door_pass    (door_pass),
    .reprogram    (reprogram),
    .expired      (expired),
    .one_hz_enable(one_hz_enable),
    .status       (status),
    .enable_siren (enable_siren),
    .start_timer  (start_timer),
    .interval     (interval)
  );

  // 10 ns free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
  endtask

  // Compare all four outputs in one call.
  task automatic check_out(input string tag, input logic st, input logic siren,
                           input logic start, input logic [1:0] intv);
    check({tag, ".status"},   {1'b0, status},       {1'b0, st});
    check({tag, ".siren"},    {1'b0, enable_siren}, {1'b0, siren});
    check({tag, ".start"},    {1'b0, start_timer},  {1'b0, start});
    check({tag, ".interval"}, interval,             intv);
  endtask

  initial begin
    reset = 1'b1; ignition = 1'b0; door_driver = 1'b0; door_pass = 1'b0;
    reprogram = 1'b0; expired = 1'b0; one_hz_enable = 1'b0;

    // Reset
    step();
    check_out("reset", 1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    step();
    check_out("idle_armed", 1'b0, 1'b0, 1'b0, 2'b00);

    // Passenger door trigger, then alarm. The door stays open to hold ALARM.
    door_pass = 1'b1;
    step();
    check_out("pass_trig", 1'b1, 1'b0, 1'b1, EXP_PASS_INT);
    step();
    check_out("trig_one_pulse", 1'b1, 1'b0, 1'b0, EXP_PASS_INT);
    expired = 1'b1;
    step();
    check_out("trig_expire", 1'b1, 1'b1, 1'b0, EXP_PASS_INT);
    expired = 1'b0;
    step();
    check_out("alarm_door_open", 1'b1, 1'b1, 1'b0, EXP_PASS_INT);

    // Alarm hold, reopen, close, expire
    door_pass = 1'b0;
    step();
    check_out("hold_start", 1'b1, 1'b1, 1'b1, 2'b11);
    step();
    check_out("hold_stay", 1'b1, 1'b1, 1'b0, 2'b11);
    door_driver = 1'b1;
    step();
    check_out("hold_reopen", 1'b1, 1'b1, 1'b0, 2'b11);
    door_driver = 1'b0;
    step();
    check_out("hold_again", 1'b1, 1'b1, 1'b1, 2'b11);
    expired = 1'b1;
    step();
    check_out("hold_expire", 1'b0, 1'b0, 1'b0, 2'b11);
    expired = 1'b0;

    // A stray expired pulse in ARMED changes nothing
    expired = 1'b1;
    step();
    check_out("armed_ign_exp", 1'b0, 1'b0, 1'b0, 2'b11);
    expired = 1'b0;

    // Status blink: four strobes, each followed by a quiet cycle
    for (int i = 0; i < 4; i++) begin
      one_hz_enable = 1'b1;
      step();
      check("blink_strobe", {1'b0, status}, {1'b0, (i % 2 == 0)});
      one_hz_enable = 1'b0;
      step();
      check("blink_hold", {1'b0, status}, {1'b0, (i % 2 == 0)});
    end

    // Both doors opened together: the driver delay wins
    door_driver = 1'b1; door_pass = 1'b1;
    step();
    check_out("both_doors", 1'b1, 1'b0, 1'b1, 2'b01);
    door_driver = 1'b0; door_pass = 1'b0;

    // Ignition during TRIGGERED, then the exit sequence
    ignition = 1'b1;
    step();
    check_out("ign_on", 1'b0, 1'b0, 1'b0, 2'b01);
    step();
    check_out("ign_hold", 1'b0, 1'b0, 1'b0, 2'b01);
    ignition = 1'b0;
    step();
    check_out("wait_open", 1'b0, 1'b0, 1'b0, 2'b01);
    door_driver = 1'b1;
    step();
    check_out("wait_close", 1'b0, 1'b0, 1'b0, 2'b01);
    door_driver = 1'b0;
    step();
    check_out("arm_delay", 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    check_out("arm_delay_run", 1'b0, 1'b0, 1'b0, 2'b00);
    door_pass = 1'b1;
    step();
    check_out("arm_restart", 1'b0, 1'b0, 1'b1, 2'b00);
    door_pass = 1'b0;
    step();
    check_out("arm_restart_end", 1'b0, 1'b0, 1'b0, 2'b00);
    expired = 1'b1;
    step();
    check_out("armed_again", 1'b0, 1'b0, 1'b0, 2'b00);
    expired = 1'b0;
    one_hz_enable = 1'b1;
    step();
    check("armed_blink", {1'b0, status}, 2'b01);
    one_hz_enable = 1'b0;

    // Reprogram held three cycles during ALARM
    door_driver = 1'b1;
    step();
    check_out("drv_trig", 1'b1, 1'b0, 1'b1, 2'b01);
    expired = 1'b1;
    step();
    check_out("drv_alarm", 1'b1, 1'b1, 1'b0, 2'b01);
    expired = 1'b0;
    reprogram = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("reprog", 1'b0, 1'b0, 1'b1, 2'b00);
    end
    reprogram = 1'b0; door_driver = 1'b0;
    step();
    check_out("reprog_release", 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset in the middle of an alarm aborts without a timer pulse
    expired = 1'b1;
    step();
    expired = 1'b0;
    door_driver = 1'b1;
    step();
    check_out("re_trig", 1'b1, 1'b0, 1'b1, 2'b01);
    expired = 1'b1;
    step();
    check_out("re_alarm", 1'b1, 1'b1, 1'b0, 2'b01);
    expired = 1'b0;
    reset = 1'b1;
    step();
    check_out("reset_alarm", 1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    door_driver = 1'b0;
    step();
    check_out("post_reset", 1'b0, 1'b0, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/antitheft_controller.md
ANTITHEFT_CONTROLLER -- requirements
Module: antitheft_controller

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous active-high reset, as listed first below.
REQ-002 The block SHALL have port clock, input, 1, system clock; all logic rising-edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 The block SHALL have port ignition, input, 1, debounced ignition switch, 1 = on.
REQ-005 The block SHALL have port door_driver, input, 1, debounced driver door, 1 = open.
REQ-006 The block SHALL have port door_pass, input, 1, debounced passenger door, 1 = open.
REQ-007 The block SHALL have port reprogram, input, 1, debounced reprogram request, level.
REQ-008 The block SHALL have port expired, input, 1, one-cycle pulse from the countdown timer.
REQ-009 The block SHALL have port one_hz_enable, input, 1, one-cycle strobe once per second.
REQ-010 The block SHALL have port status, output, 1, status LED.
REQ-011 The block SHALL have port enable_siren, output, 1, siren gate to the siren generator.
REQ-012 The block SHALL have port start_timer, output, 1, one-cycle timer load/start pulse.
REQ-013 The block SHALL have port interval, output, 2, timer parameter select: 00 arm delay, 01 driver delay, 10 passenger delay, 11 alarm-on time.

Function
REQ-014 States SHALL be: ARMED, TRIGGERED, ALARM, ALARM_HOLD, IGN_ON, WAIT_OPEN, WAIT_CLOSE, ARM_DELAY.
REQ-015 Transition priority per cycle SHALL be: reset > reprogram > ignition > door/expired events.
REQ-016 reprogram=1 in any state SHALL force ARM_DELAY, start_timer=1 and interval=00, and SHALL re-pulse every cycle while held.
REQ-017 ignition=1 in any state except IGN_ON SHALL force IGN_ON next cycle; IGN_ON SHALL persist while ignition=1.
REQ-018 IGN_ON with ignition=0 SHALL go to WAIT_OPEN; WAIT_OPEN with door_driver=1 SHALL go to WAIT_CLOSE; WAIT_CLOSE with door_driver=0 SHALL go to ARM_DELAY with start_timer pulse and interval=00.
REQ-019 In ARM_DELAY, door_driver or door_pass =1 SHALL re-pulse start_timer (interval 00) each such cycle; expired with both doors closed SHALL go to ARMED.
REQ-020 In ARMED, door_driver=1 SHALL go to TRIGGERED with start_timer and interval=01; else door_pass=1 SHALL do so with interval=10; driver SHALL win if both open.
REQ-021 In TRIGGERED, expired SHALL go to ALARM; doors closing SHALL NOT cancel the countdown.
REQ-022 In ALARM, both doors closed SHALL go to ALARM_HOLD with start_timer and interval=11; ALARM_HOLD with either door open SHALL return to ALARM; ALARM_HOLD with expired SHALL go to ARMED.
REQ-023 expired SHALL be ignored in states not named in REQ-019, REQ-021 and REQ-022.
REQ-024 enable_siren SHALL be 1 exactly in ALARM and ALARM_HOLD.
REQ-025 status SHALL toggle on each one_hz_enable in ARMED (2 s period), be 1 in TRIGGERED/ALARM/ALARM_HOLD, and be 0 elsewhere; status SHALL be 0 on the cycle ARMED is entered.
REQ-026 All outputs SHALL be registered; start_timer SHALL be high exactly one cycle per start event, with interval valid that cycle and held until the next start.

Reset
REQ-027 Reset SHALL set the state to ARMED, status=0, enable_siren=0, start_timer=0 and interval=00 on the next clock edge.
REQ-028 Reset mid-countdown or mid-alarm SHALL abort immediately with no start_timer pulse.

Configuration
REQ-029 Macro ANTITHEFT_PASSENGER_DELAY_EN defined SHALL select interval=10 for passenger-door triggers.
REQ-030 Without ANTITHEFT_PASSENGER_DELAY_EN, a passenger-door trigger SHALL use interval=01, and interval SHALL never take the value 10.

Verification
REQ-031 The bench SHALL cover: reset; door_pass=1 in ARMED -> TRIGGERED, one start_timer pulse, interval=10 (01 without macro); expired -> enable_siren=1.
REQ-032 The bench SHALL cover: in ALARM, close both doors -> start_timer with interval=11; reopen driver door -> ALARM; close, expired -> ARMED, enable_siren=0.
REQ-033 The bench SHALL cover: ignition=1 during TRIGGERED -> IGN_ON, status=0; then ignition=0, open/close driver door -> start_timer with interval=00; open door_pass during delay -> restart; expired -> ARMED.
REQ-034 The bench SHALL cover: ARMED with 4 one_hz_enable strobes -> status sequence 1,0,1,0.
REQ-035 The bench SHALL cover: reprogram held 3 cycles during ALARM -> ARM_DELAY, 3 start_timer pulses, interval=00, enable_siren=0.
REQ-036 The bench SHALL cover: door_driver and door_pass asserted together in ARMED -> interval=01.
